// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute stage: opcodes, funct codes,
// main-decoder ALU op classes, ALU function selects and the control-strobe bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  typedef struct packed {
    logic regdst;
    logic alusrc;
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch_eq;
    logic branch_ne;
    logic jump;
    logic jump_reg;
    logic jal;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_core.sv
// Purely combinational WIDTH-bit ALU: AND/OR/NOR/ADD/SUB/signed SLT, any other
// select yields zero. Arithmetic wraps modulo 2^WIDTH with no overflow flag.
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS decode/execute: main decoder, ALU-control decoder, immediate
// extension and ALU, with every output registered once as the ID/EX boundary.
module mips_decode_execute
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             branch_taken,
  output logic [WIDTH-1:0] imm_ext,
  output logic [1:0]       aluop,
  output logic [3:0]       alu_ctrl,
  output logic             regdst,
  output logic             alusrc,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             jump,
  output logic             jump_reg,
  output logic             jal
);

  // No handshake: a new instruction is accepted every cycle and its results
  // appear on the outputs after the next rising clk edge, unconditionally.

  logic [5:0]       opcode;
  logic [5:0]       funct;
  ctrl_t            ctrl_c;
  ctrl_t            ctrl_r;
  logic [1:0]       aluop_c;
  logic [3:0]       alu_ctrl_c;
  logic [WIDTH-1:0] imm_c;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result_c;
  logic             zero_c;
  logic             taken_c;
  logic             unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:16];

  always_comb begin
    ctrl_c  = '0;
    aluop_c = ALUOP_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl_c.regdst = 1'b1;
        aluop_c       = ALUOP_FUNCT;
        // jr shares the R-type opcode but must not write the register file
        if (funct == F_JR) ctrl_c.jump_reg = 1'b1;
        else               ctrl_c.regwrite = 1'b1;
      end
      OP_LW: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.memtoreg = 1'b1;
        ctrl_c.regwrite = 1'b1;
        ctrl_c.memread  = 1'b1;
      end
      OP_SW: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.memwrite = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c.branch_eq = 1'b1;
        aluop_c          = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl_c.branch_ne = 1'b1;
        aluop_c          = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.regwrite = 1'b1;
      end
      OP_ORI: begin
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.regwrite = 1'b1;
        aluop_c         = ALUOP_OR;
      end
      OP_J: ctrl_c.jump = 1'b1;
      OP_JAL: begin
        ctrl_c.jump     = 1'b1;
        ctrl_c.jal      = 1'b1;
        ctrl_c.regwrite = 1'b1;
      end
      default: ctrl_c = '0;
    endcase
  end

  always_comb begin
    alu_ctrl_c = ALU_ADD;
    case (aluop_c)
      ALUOP_ADD: alu_ctrl_c = ALU_ADD;
      ALUOP_SUB: alu_ctrl_c = ALU_SUB;
      ALUOP_OR:  alu_ctrl_c = ALU_OR;
      default: begin
        case (funct)
          F_ADD:   alu_ctrl_c = ALU_ADD;
          F_SUB:   alu_ctrl_c = ALU_SUB;
          F_AND:   alu_ctrl_c = ALU_AND;
          F_OR:    alu_ctrl_c = ALU_OR;
          F_SLT:   alu_ctrl_c = ALU_SLT;
          F_NOR:   alu_ctrl_c = ALU_NOR;
          default: alu_ctrl_c = ALU_NONE;
        endcase
      end
    endcase
  end

  assign imm_c     = {{(WIDTH-16){instr[15]}}, instr[15:0]};
  assign operand_b = ctrl_c.alusrc ? imm_c : rt_data;

  mips_alu_core #(.WIDTH(WIDTH)) u_alu (
    .ctrl   (alu_ctrl_c),
    .a      (rs_data),
    .b      (operand_b),
    .result (result_c),
    .zero   (zero_c)
  );

  assign taken_c = (ctrl_c.branch_eq & zero_c) | (ctrl_c.branch_ne & ~zero_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result   <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      imm_ext      <= '0;
      aluop        <= '0;
      alu_ctrl     <= '0;
      ctrl_r       <= '0;
    end else begin
      alu_result   <= result_c;
      zero         <= zero_c;
      branch_taken <= taken_c;
      imm_ext      <= imm_c;
      aluop        <= aluop_c;
      alu_ctrl     <= alu_ctrl_c;
      ctrl_r       <= ctrl_c;
    end
  end

  assign regdst    = ctrl_r.regdst;
  assign alusrc    = ctrl_r.alusrc;
  assign memtoreg  = ctrl_r.memtoreg;
  assign regwrite  = ctrl_r.regwrite;
  assign memread   = ctrl_r.memread;
  assign memwrite  = ctrl_r.memwrite;
  assign branch_eq = ctrl_r.branch_eq;
  assign branch_ne = ctrl_r.branch_ne;
  assign jump      = ctrl_r.jump;
  assign jump_reg  = ctrl_r.jump_reg;
  assign jal       = ctrl_r.jal;

endmodule

// File: tb/tb_mips_decode_execute.sv
// Bench for mips_decode_execute: directed and random instructions, expected
// outputs queued from an instruction-level reference model and popped by a monitor.
module tb_mips_decode_execute;

  typedef struct packed {
    logic [31:0] alu_result;
    logic        zero;
    logic        branch_taken;
    logic [31:0] imm_ext;
    logic [1:0]  aluop;
    logic [3:0]  alu_ctrl;
    logic        regdst;
    logic        alusrc;
    logic        memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic        jump_reg;
    logic        jal;
  } exp_t;

  localparam int EW = $bits(exp_t);

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_result;
  logic        zero;
  logic        branch_taken;
  logic [31:0] imm_ext;
  logic [1:0]  aluop;
  logic [3:0]  alu_ctrl;
  logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite;
  logic        branch_eq, branch_ne, jump, jump_reg, jal;

  logic        in_valid;
  logic [EW-1:0] exp_q[$];
  exp_t        act;
  int          checks;
  int          errors;
  int          txn;

  mips_decode_execute #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .alu_result   (alu_result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .aluop        (aluop),
    .alu_ctrl     (alu_ctrl),
    .regdst       (regdst),
    .alusrc       (alusrc),
    .memtoreg     (memtoreg),
    .regwrite     (regwrite),
    .memread      (memread),
    .memwrite     (memwrite),
    .branch_eq    (branch_eq),
    .branch_ne    (branch_ne),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .jal          (jal)
  );

  assign act = '{alu_result, zero, branch_taken, imm_ext, aluop, alu_ctrl,
                 regdst, alusrc, memtoreg, regwrite, memread, memwrite,
                 branch_eq, branch_ne, jump, jump_reg, jal};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] b;
    logic [31:0] r;
    int          sa;
    int          sb;
    e  = '0;
    op = ins[31:26];
    fn = ins[5:0];
    e.imm_ext = {{16{ins[15]}}, ins[15:0]};
    if (op == 6'd0) begin
      e.regdst = 1; e.aluop = 2'd2;
      if (fn == 6'd8) e.jump_reg = 1; else e.regwrite = 1;
    end else if (op == 6'd35) begin
      e.alusrc = 1; e.memtoreg = 1; e.regwrite = 1; e.memread = 1;
    end else if (op == 6'd43) begin
      e.alusrc = 1; e.memwrite = 1;
    end else if (op == 6'd4) begin
      e.branch_eq = 1; e.aluop = 2'd1;
    end else if (op == 6'd5) begin
      e.branch_ne = 1; e.aluop = 2'd1;
    end else if (op == 6'd8) begin
      e.alusrc = 1; e.regwrite = 1;
    end else if (op == 6'd13) begin
      e.alusrc = 1; e.regwrite = 1; e.aluop = 2'd3;
    end else if (op == 6'd2) begin
      e.jump = 1;
    end else if (op == 6'd3) begin
      e.jump = 1; e.jal = 1; e.regwrite = 1;
    end
    if (e.aluop == 2'd0)      e.alu_ctrl = 4'd2;
    else if (e.aluop == 2'd1) e.alu_ctrl = 4'd6;
    else if (e.aluop == 2'd3) e.alu_ctrl = 4'd1;
    else if (fn == 6'd32)     e.alu_ctrl = 4'd2;
    else if (fn == 6'd34)     e.alu_ctrl = 4'd6;
    else if (fn == 6'd36)     e.alu_ctrl = 4'd0;
    else if (fn == 6'd37)     e.alu_ctrl = 4'd1;
    else if (fn == 6'd42)     e.alu_ctrl = 4'd7;
    else if (fn == 6'd39)     e.alu_ctrl = 4'd12;
    else                      e.alu_ctrl = 4'd15;
    b  = e.alusrc ? e.imm_ext : rt;
    sa = a;
    sb = b;
    case (e.alu_ctrl)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd12:   r = ~(a | b);
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd7:    r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    e.alu_result   = r;
    e.zero         = (r == 32'd0);
    e.branch_taken = (e.branch_eq && e.zero) || (e.branch_ne && !e.zero);
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr    = ins;
    rs_data  = a;
    rt_data  = b;
    in_valid = 1'b1;
    exp_q.push_back(model(ins, a, b));
    @(posedge clk);
    #3;
  endtask

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    @(posedge clk);
    if (in_valid) begin
      #2;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow got=%h exp=none", act);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL txn%0d instr=%h got=%h exp=%h", txn, instr, act, e);
        end
      end
      txn++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0]  ops [10];
    logic [5:0]  fns [8];
    logic [31:0] r, a, b;
    logic [5:0]  op, fn;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h03, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h08, 6'h20};
    checks   = 0;
    errors   = 0;
    txn      = 0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    instr    = 32'h8C220004;
    rs_data  = 32'h100;
    rt_data  = 32'h0;

    repeat (2) @(negedge clk);
    #1 check("reset_all_zero", act, '0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    check("lw_memread", EW'(memread), EW'(1));
    check("lw_memtoreg", EW'(memtoreg), EW'(1));
    check("lw_alusrc", EW'(alusrc), EW'(1));
    check("lw_regwrite", EW'(regwrite), EW'(1));
    check("lw_alu_ctrl", EW'(alu_ctrl), EW'(4'b0010));
    check("lw_result", EW'(alu_result), EW'(32'h104));

    issue(32'h00221820, 32'd5, 32'd7);
    check("add_result", EW'(alu_result), EW'(12));
    check("add_regdst", EW'(regdst), EW'(1));
    check("add_aluop", EW'(aluop), EW'(2'b10));
    issue(32'h0022182A, 32'hFFFFFFFF, 32'd1);
    check("slt_neg", EW'(alu_result), EW'(1));
    issue(32'h0022182A, 32'd1, 32'hFFFFFFFF);
    check("slt_swap", EW'({alu_result, zero}), EW'({32'd0, 1'b1}));
    issue(32'h10220004, 32'd9, 32'd9);
    check("beq_taken", EW'({zero, branch_taken}), EW'(2'b11));
    issue(32'h14220004, 32'd9, 32'd9);
    check("bne_not_taken", EW'(branch_taken), EW'(0));
    issue(32'h14220004, 32'd9, 32'd3);
    check("bne_taken", EW'(branch_taken), EW'(1));
    issue(32'h2022FFFF, 32'd1, 32'd0);
    check("addi_imm", EW'(imm_ext), EW'(32'hFFFFFFFF));
    check("addi_zero", EW'({alu_result, zero}), EW'({32'd0, 1'b1}));
    issue(32'h342200F0, 32'h0F, 32'd0);
    check("ori_result", EW'(alu_result), EW'(32'hFF));
    issue(32'h0C000010, 32'd0, 32'd0);
    check("jal_strobes", EW'({jump, jal, regwrite}), EW'(3'b111));
    issue(32'h03E00008, 32'd4, 32'd0);
    check("jr_strobes", EW'({jump_reg, regwrite, alu_ctrl}), EW'({2'b10, 4'b1111}));
    issue(32'hFC000000, 32'd3, 32'd4);
    check("unknown_strobes",
          EW'({regdst, alusrc, memtoreg, regwrite, memread, memwrite,
               branch_eq, branch_ne, jump, jump_reg, jal, aluop}), EW'(0));

    for (int i = 0; i < 300; i++) begin
      r  = $urandom();
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : fns[$urandom_range(0, 7)];
      a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 20));
        default: b = $urandom();
      endcase
      issue({op, r[25:6], fn}, a, b);
    end

    // asynchronous reset in the middle of a cycle clears the outputs at once
    issue(32'h8C220004, 32'h100, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset_zero", act, '0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h00221822, 32'd10, 32'd3);
    check("sub_after_reset", EW'(alu_result), EW'(7));
    issue(32'h00221827, 32'h0F0F0000, 32'h000000F0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 check("queue_drained", EW'(exp_q.size()), EW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
